mux_stream_arb: RTL and testbench

MUX_STREAM_ARB -- requirements
Module: mux_stream_arb

---
 rtl/mux_stream_arb.sv | 116 +++++++++++
 tb/tb_mux_stream_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_arb.sv
// Two-input stream arbiter feeding a single-entry output register.
// Round-robin between channels A and B when both are valid, with
// saturating per-channel acceptance counters.
module mux_stream_arb #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             a_valid_i,
   input  logic [WIDTH-1:0] a_data_i,
   output logic             a_ready_o,

   input  logic             b_valid_i,
   input  logic [WIDTH-1:0] b_data_i,
   output logic             b_ready_o,

   output logic             y_valid_o,
   output logic [WIDTH-1:0] y_data_o,
   input  logic             y_ready_i,

   output logic             sel_o,
   output logic [CNT_W-1:0] cnt_a_o,
   output logic [CNT_W-1:0] cnt_b_o
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic             y_valid_q, y_valid_d;
   logic [WIDTH-1:0] y_data_q,  y_data_d;
   logic             sel_q,     sel_d;
   // 1 = B was granted last, so A wins the next contention.
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   logic can_accept;
   logic grant_a, grant_b;
   logic accept_a, accept_b;

   // Arbitration and handshake decode.
   always_comb begin
      can_accept = !y_valid_q || y_ready_i;
      grant_a    = a_valid_i && (!b_valid_i || last_grant_q);
      grant_b    = b_valid_i && (!a_valid_i || !last_grant_q);
      // Readies are forced low while reset is high so nothing is accepted on that edge.
      a_ready_o  = can_accept && grant_a && !reset;
      b_ready_o  = can_accept && grant_b && !reset;
      accept_a   = a_ready_o && a_valid_i;
      accept_b   = b_ready_o && b_valid_i;
   end

   // Next-state for the output register and round-robin pointer.
   always_comb begin
      y_valid_d    = y_valid_q;
      y_data_d     = y_data_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      if (accept_a) begin
         y_valid_d    = 1'b1;
         y_data_d     = a_data_i;
         sel_d        = 1'b0;
         last_grant_d = 1'b0;
      end else if (accept_b) begin
         y_valid_d    = 1'b1;
         y_data_d     = b_data_i;
         sel_d        = 1'b1;
         last_grant_d = 1'b1;
      end else if (y_valid_q && y_ready_i) begin
         // Drain without refill: payload and source are left as-is.
         y_valid_d = 1'b0;
      end
   end

   // Next-state for the saturating acceptance counters.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (accept_a && (cnt_a_q != CntMax)) begin
         cnt_a_d = cnt_a_q + 1'b1;
      end
      if (accept_b && (cnt_b_q != CntMax)) begin
         cnt_b_d = cnt_b_q + 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_valid_q    <= 1'b0;
         y_data_q     <= '0;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_a_q      <= '0;
         cnt_b_q      <= '0;
      end else begin
         y_valid_q    <= y_valid_d;
         y_data_q     <= y_data_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         cnt_a_q      <= cnt_a_d;
         cnt_b_q      <= cnt_b_d;
      end
   end

   // Output mapping.
   always_comb begin
      y_valid_o = y_valid_q;
      y_data_o  = y_data_q;
      sel_o     = sel_q;
      cnt_a_o   = cnt_a_q;
      cnt_b_o   = cnt_b_q;
   end

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed and randomised bench for mux_stream_arb.
module tb_mux_stream_arb;

   logic        clk;
   logic        reset;
   logic        a_valid, b_valid, y_ready;
   logic [7:0]  a_data, b_data;
   logic        a_ready, b_ready, y_valid, sel;
   logic [7:0]  y_data;
   logic [15:0] cnt_a, cnt_b;

   logic        s_a_ready, s_b_ready, s_y_valid, s_sel;
   logic [7:0]  s_y_data;
   logic [1:0]  s_cnt_a, s_cnt_b;

   int errors = 0;
   int checks = 0;

   mux_stream_arb #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
      .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
      .y_valid_o(y_valid), .y_data_o(y_data), .y_ready_i(y_ready),
      .sel_o(sel), .cnt_a_o(cnt_a), .cnt_b_o(cnt_b)
   );

   mux_stream_arb #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(s_a_ready),
      .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(s_b_ready),
      .y_valid_o(s_y_valid), .y_data_o(s_y_data), .y_ready_i(y_ready),
      .sel_o(s_sel), .cnt_a_o(s_cnt_a), .cnt_b_o(s_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
      a_data = 8'h12; b_data = 8'h34;
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      tick();
      reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (y_valid !== 1'b0 || y_data !== 8'h00 || sel !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: got v=%b d=%h s=%b want 0 00 0", y_valid, y_data, sel);
      end
      checks++;
      if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: got a=%0d b=%0d want 0 0", cnt_a, cnt_b);
      end
   endtask

   task automatic test_alternate();
      logic [7:0] exp_d [4];
      exp_d = '{8'hAA, 8'h55, 8'hAA, 8'h55};
      do_reset();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'h55; y_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL alt_ready[%0d]: got a=%b b=%b want a=%b", i, a_ready, b_ready,
                     (i % 2 == 0));
         end
         tick();
         checks++;
         if (y_valid !== 1'b1 || y_data !== exp_d[i] || sel !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL alt_out[%0d]: got v=%b d=%h s=%b want 1 %h %b", i, y_valid, y_data,
                     sel, exp_d[i], (i % 2 == 1));
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (cnt_a !== 16'd2 || cnt_b !== 16'd2) begin
         errors++;
         $display("FAIL alt_cnt: got a=%0d b=%0d want 2 2", cnt_a, cnt_b);
      end
   endtask

   task automatic test_b_only();
      do_reset();
      a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h0F; y_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bonly_ready[%0d]: got a=%b b=%b want 0 1", i, a_ready, b_ready);
         end
         tick();
         checks++;
         if (y_valid !== 1'b1 || y_data !== 8'h0F || sel !== 1'b1) begin
            errors++;
            $display("FAIL bonly_out[%0d]: got v=%b d=%h s=%b want 1 0f 1", i, y_valid,
                     y_data, sel);
         end
      end
      b_valid = 1'b0;
      checks++;
      if (cnt_b !== 16'd3 || cnt_a !== 16'd0) begin
         errors++;
         $display("FAIL bonly_cnt: got a=%0d b=%0d want 0 3", cnt_a, cnt_b);
      end
   endtask

   task automatic test_drain();
      // One beat from A, then drain with no new input: valid drops, payload holds.
      do_reset();
      a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b0; y_ready = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      checks++;
      if (y_valid !== 1'b0 || y_data !== 8'h3C || sel !== 1'b0) begin
         errors++;
         $display("FAIL drain: got v=%b d=%h s=%b want 0 3c 0", y_valid, y_data, sel);
      end
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
   endtask

   task automatic test_stall();
      do_reset();
      a_valid = 1'b1; a_data = 8'hF0; b_valid = 1'b0; y_ready = 1'b0;
      tick();
      a_data = 8'h11; b_valid = 1'b1; b_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready[%0d]: got a=%b b=%b want 0 0", i, a_ready, b_ready);
         end
         tick();
         checks++;
         if (y_valid !== 1'b1 || y_data !== 8'hF0 || sel !== 1'b0 ||
             cnt_a !== 16'd1 || cnt_b !== 16'd0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%b ca=%0d cb=%0d want 1 f0 0 1 0",
                     i, y_valid, y_data, sel, cnt_a, cnt_b);
         end
      end
      y_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got a=%b b=%b want 0 1", a_ready, b_ready);
      end
      tick();
      checks++;
      if (y_data !== 8'h77 || sel !== 1'b1 || cnt_b !== 16'd1) begin
         errors++;
         $display("FAIL stall_grant_b: got d=%h s=%b cb=%0d want 77 1 1", y_data, sel, cnt_b);
      end
   endtask

   task automatic test_mid_reset();
      // Continues from a loaded register with both inputs valid.
      a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA1; b_data = 8'hB2; y_ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      tick();
      reset = 1'b0;
      checks++;
      if (y_valid !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
         errors++;
         $display("FAIL midrst_out: got v=%b ca=%0d cb=%0d want 0 0 0", y_valid, cnt_a, cnt_b);
      end
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_first: got a=%b b=%b want 1 0", a_ready, b_ready);
      end
      tick();
      checks++;
      if (y_data !== 8'hA1 || sel !== 1'b0) begin
         errors++;
         $display("FAIL midrst_beat: got d=%h s=%b want a1 0", y_data, sel);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_saturate();
      logic [1:0] exp_c;
      do_reset();
      a_valid = 1'b1; b_valid = 1'b0; a_data = 8'h5A; y_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++;
         if (s_cnt_a !== exp_c) begin
            errors++;
            $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, s_cnt_a, exp_c);
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic test_random();
      int a_seq = 0, b_seq = 0, a_exp = 0, b_exp = 0;
      int a_run = 0, b_run = 0, a_acc = 0, b_acc = 0;
      logic a_hs, b_hs, y_hs;
      logic [7:0] exp_d;
      do_reset();
      a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      a_data = 8'h00; b_data = 8'h00;
      for (int cyc = 0; cyc < 3004; cyc++) begin
         @(negedge clk);
         a_hs = a_valid && a_ready;
         b_hs = b_valid && b_ready;
         y_hs = y_valid && y_ready;
         if (a_hs && b_hs) begin
            errors++;
            checks++;
            $display("FAIL rnd_both_ready: cycle %0d got two readies want one", cyc);
         end
         if (y_hs) begin
            exp_d = sel ? b_exp[7:0] : a_exp[7:0];
            checks++;
            if (y_data !== exp_d) begin
               errors++;
               $display("FAIL rnd_data: cycle %0d sel=%b got %h want %h", cyc, sel, y_data, exp_d);
            end
            if (sel) b_exp++;
            else a_exp++;
         end
         if (a_hs) begin
            a_acc++;
            a_run = b_valid ? a_run + 1 : 0;
            b_run = 0;
            checks++;
            if (a_run > 1) begin
               errors++;
               $display("FAIL rnd_fair_b: cycle %0d B passed over %0d times want <=1", cyc, a_run);
            end
         end
         if (b_hs) begin
            b_acc++;
            b_run = a_valid ? b_run + 1 : 0;
            a_run = 0;
            checks++;
            if (b_run > 1) begin
               errors++;
               $display("FAIL rnd_fair_a: cycle %0d A passed over %0d times want <=1", cyc, b_run);
            end
         end
         tick();
         if (a_hs) a_seq++;
         if (b_hs) b_seq++;
         if (cyc >= 3000) begin
            a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
         end else begin
            if (a_hs || !a_valid) a_valid = ($urandom_range(0, 2) != 0);
            if (b_hs || !b_valid) b_valid = ($urandom_range(0, 2) != 0);
            y_ready = ($urandom_range(0, 3) != 0);
         end
         a_data = a_seq[7:0];
         b_data = b_seq[7:0];
      end
      checks++;
      if (a_exp !== a_seq || b_exp !== b_seq) begin
         errors++;
         $display("FAIL rnd_lost: got out a=%0d b=%0d want a=%0d b=%0d", a_exp, b_exp, a_seq,
                  b_seq);
      end
      checks++;
      if (cnt_a !== 16'(a_acc) || cnt_b !== 16'(b_acc)) begin
         errors++;
         $display("FAIL rnd_cnt: got a=%0d b=%0d want a=%0d b=%0d", cnt_a, cnt_b, a_acc, b_acc);
      end
   endtask

   initial begin
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      a_data = 8'h00; b_data = 8'h00;
      tick();
      test_reset();
      test_alternate();
      test_b_only();
      test_drain();
      test_stall();
      test_mid_reset();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
